// File: rtl/alu_sequencer_if.sv
// Issue/result bus of the ALU sequencer: operand handshake in, ALU drive and
// sample signals, and the result handshake out.
interface alu_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [2:0]        op;
    logic [DATA_W-1:0] ops;
    logic              zf;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              illegal;
    logic              divz;

    // Environment side: register-file read stage, ALU and write-back consumer.
    modport master (
        output in_valid, instr, rs_val, rt_val, ops, zf, out_ready,
        input  in_ready, op1, op2, op, out_valid, result, zero, illegal, divz
    );

    // Sequencer side.
    modport slave (
        input  in_valid, instr, rs_val, rt_val, ops, zf, out_ready,
        output in_ready, op1, op2, op, out_valid, result, zero, illegal, divz
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue-side controller for the 32-bit ALU: decodes the funct field, holds the
// ALU inputs for an operation-dependent number of cycles, then captures the
// ALU result and returns it over a valid/ready handshake.
module alu_sequencer #(
    parameter int ALU_LAT    = 1,
    parameter int MULDIV_LAT = 4,
    parameter int DATA_W     = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    alu_sequencer_if.slave io_bus
);

    localparam int MAX_LAT = (ALU_LAT > MULDIV_LAT) ? ALU_LAT : MULDIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] ALU_LOAD    = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_LAT - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_illegal;
    logic              r_divz;

    logic              w_accept;
    logic              w_legal;
    logic [2:0]        w_code;
    logic              w_is_muldiv;
    logic              w_div_zero;
    logic              w_cnt_done;
    logic              w_unused_instr;

    // {legal, opcode} for a funct field; illegal functs map to NOP.
    function automatic logic [3:0] decode_funct(input logic [5:0] funct);
        logic [3:0] dec;
        case (funct)
            6'b100100: dec = {1'b1, OP_AND};
            6'b100101: dec = {1'b1, OP_OR};
            6'b100000: dec = {1'b1, OP_ADD};
            6'b100010: dec = {1'b1, OP_SUB};
            6'b101010: dec = {1'b1, OP_SLT};
            6'b011010: dec = {1'b1, OP_DIV};
            6'b000000: dec = {1'b1, OP_NOP};
            6'b011000: dec = {1'b1, OP_MUL};
            default:   dec = {1'b0, OP_NOP};
        endcase
        return dec;
    endfunction

    // Only the funct field selects the operation; the rest of the word is ignored.
    assign w_unused_instr = ^io_bus.instr[31:6];

    assign {w_legal, w_code} = decode_funct(io_bus.instr[5:0]);
    assign w_accept    = io_bus.in_valid && (r_state == S_IDLE);
    assign w_is_muldiv = (w_code == OP_MUL) || (w_code == OP_DIV);
    assign w_div_zero  = w_legal && (w_code == OP_DIV) && (io_bus.rt_val == '0);
    assign w_cnt_done  = (r_cnt == '0);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> EXEC (or straight to DONE on a rejected op) -> DONE -> IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (!w_legal || w_div_zero) ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_cnt_done) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (io_bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ALU drive registers, hold counter and captured result/flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_op      <= OP_NOP;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
            r_divz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op1 <= io_bus.rs_val;
                        r_op2 <= io_bus.rt_val;
                        if (!w_legal || w_div_zero) begin
                            // Park the ALU on NOP so it never sees a bad op or a zero divisor.
                            r_op      <= OP_NOP;
                            r_result  <= '0;
                            r_zero    <= 1'b1;
                            r_illegal <= !w_legal;
                            r_divz    <= w_div_zero;
                        end else begin
                            r_op  <= w_code;
                            r_cnt <= w_is_muldiv ? MULDIV_LOAD : ALU_LOAD;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_cnt_done) begin
                        r_result  <= io_bus.ops;
                        r_zero    <= ~io_bus.zf;
                        r_illegal <= 1'b0;
                        r_divz    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.in_ready  = (r_state == S_IDLE);
    assign io_bus.out_valid = (r_state == S_DONE);
    assign io_bus.op1       = r_op1;
    assign io_bus.op2       = r_op2;
    assign io_bus.op        = r_op;
    assign io_bus.result    = r_result;
    assign io_bus.zero      = r_zero;
    assign io_bus.illegal   = r_illegal;
    assign io_bus.divz      = r_divz;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU on the bus, a table of single
// operations, and hand-written backpressure and mid-operation reset sequences.
module tb_alu_sequencer;

    localparam int ALU_LAT    = 1;
    localparam int MULDIV_LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.DATA_W(32)) bus ();

    alu_sequencer #(
        .ALU_LAT   (ALU_LAT),
        .MULDIV_LAT(MULDIV_LAT),
        .DATA_W    (32)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    // Behavioural ALU driven by OP1/OP2/OP.
    always_comb begin
        logic [63:0] prod;
        logic [31:0] res;
        prod = 64'(bus.op1) * 64'(bus.op2);
        res  = 32'h0;
        case (bus.op)
            3'b000: res = bus.op1 & bus.op2;
            3'b001: res = bus.op1 | bus.op2;
            3'b010: res = bus.op1 + bus.op2;
            3'b011: res = bus.op1 - bus.op2;
            3'b100: res = {31'h0, ($signed(bus.op1) < $signed(bus.op2))};
            3'b101: res = (bus.op2 == 32'h0) ? 32'hDEADBEEF
                                             : 32'($signed(bus.op1) / $signed(bus.op2));
            3'b110: res = 32'h0;
            default: res = prod[31:0];
        endcase
        bus.ops = res;
        bus.zf  = |res;
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [2:0]  exp_op;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
        logic        exp_divz;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int          lat;
        logic [2:0]  first_op;
        logic        stable;

        vecs[0]  = '{6'b100000, 32'd5,        32'd7,        3'b010, 32'd12,      1'b0, 1'b0, 1'b0, ALU_LAT + 1};
        vecs[1]  = '{6'b100010, 32'h1234,     32'h1234,     3'b011, 32'h0,       1'b1, 1'b0, 1'b0, ALU_LAT + 1};
        vecs[2]  = '{6'b011000, 32'd3,        32'h10,       3'b111, 32'h30,      1'b0, 1'b0, 1'b0, MULDIV_LAT + 1};
        vecs[3]  = '{6'b011010, 32'd100,      32'd0,        3'b110, 32'h0,       1'b1, 1'b0, 1'b1, 1};
        vecs[4]  = '{6'b011010, 32'd100,      32'd7,        3'b101, 32'd14,      1'b0, 1'b0, 1'b0, MULDIV_LAT + 1};
        vecs[5]  = '{6'b100100, 32'hF0F0,     32'hFF00,     3'b000, 32'hF000,    1'b0, 1'b0, 1'b0, ALU_LAT + 1};
        vecs[6]  = '{6'b100101, 32'hF0,       32'h0F,       3'b001, 32'hFF,      1'b0, 1'b0, 1'b0, ALU_LAT + 1};
        vecs[7]  = '{6'b101010, 32'hFFFFFFFF, 32'd1,        3'b100, 32'd1,       1'b0, 1'b0, 1'b0, ALU_LAT + 1};
        vecs[8]  = '{6'b000000, 32'd5,        32'd6,        3'b110, 32'h0,       1'b1, 1'b0, 1'b0, ALU_LAT + 1};
        vecs[9]  = '{6'b111111, 32'd9,        32'd9,        3'b110, 32'h0,       1'b1, 1'b1, 1'b0, 1};
        vecs[10] = '{6'b100000, 32'hFFFFFFFF, 32'd1,        3'b010, 32'h0,       1'b1, 1'b0, 1'b0, ALU_LAT + 1};
        vecs[11] = '{6'b011000, 32'h10000,    32'h10000,    3'b111, 32'h0,       1'b1, 1'b0, 1'b0, MULDIV_LAT + 1};

        bus.in_valid  = 1'b0;
        bus.instr     = 32'h0;
        bus.rs_val    = 32'h0;
        bus.rt_val    = 32'h0;
        bus.out_ready = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #20;
        chk1 ("rst in_ready",  bus.in_ready,  1'b1);
        chk1 ("rst out_valid", bus.out_valid, 1'b0);
        chk32("rst op1",       bus.op1,       32'h0);
        chk32("rst op2",       bus.op2,       32'h0);
        chk32("rst op",        32'(bus.op),   32'h6);
        chk32("rst result",    bus.result,    32'h0);
        chk1 ("rst zero",      bus.zero,      1'b1);
        chk1 ("rst illegal",   bus.illegal,   1'b0);
        chk1 ("rst divz",      bus.divz,      1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single operations with the consumer always ready
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk1($sformatf("v%0d in_ready", i), bus.in_ready, 1'b1);
            bus.in_valid = 1'b1;
            bus.instr    = {26'h2A5A5A5, vecs[i].funct};
            bus.rs_val   = vecs[i].rs;
            bus.rt_val   = vecs[i].rt;
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat = 1;
            chk32($sformatf("v%0d op", i),  32'(bus.op), 32'(vecs[i].exp_op));
            chk32($sformatf("v%0d op1", i), bus.op1,     vecs[i].rs);
            chk32($sformatf("v%0d op2", i), bus.op2,     vecs[i].rt);
            first_op = bus.op;
            stable   = 1'b1;
            while (!bus.out_valid && lat < 20) begin
                if (bus.op !== first_op || bus.in_ready !== 1'b0) stable = 1'b0;
                @(negedge clk);
                lat++;
            end
            if (bus.op !== first_op) stable = 1'b0;
            chk32($sformatf("v%0d latency", i), 32'(lat),    32'(vecs[i].exp_lat));
            chk32($sformatf("v%0d result", i),  bus.result,  vecs[i].exp_res);
            chk1 ($sformatf("v%0d zero", i),    bus.zero,    vecs[i].exp_zero);
            chk1 ($sformatf("v%0d illegal", i), bus.illegal, vecs[i].exp_ill);
            chk1 ($sformatf("v%0d divz", i),    bus.divz,    vecs[i].exp_divz);
            chk1 ($sformatf("v%0d op held", i), stable,      1'b1);
            @(negedge clk);
            chk1($sformatf("v%0d done 1 cycle", i), bus.out_valid, 1'b0);
        end

        // Illegal op under backpressure with a second request waiting
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h0000003F;
        bus.rs_val    = 32'd1;
        bus.rt_val    = 32'd2;
        @(negedge clk);
        bus.instr  = 32'h00000020;
        bus.rs_val = 32'h11;
        bus.rt_val = 32'h22;
        for (int k = 0; k < 5; k++) begin
            chk1 ($sformatf("bp%0d out_valid", k), bus.out_valid, 1'b1);
            chk1 ($sformatf("bp%0d illegal", k),   bus.illegal,   1'b1);
            chk1 ($sformatf("bp%0d in_ready", k),  bus.in_ready,  1'b0);
            chk32($sformatf("bp%0d op", k),        32'(bus.op),   32'h6);
            chk32($sformatf("bp%0d result", k),    bus.result,    32'h0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk1("bp release out_valid", bus.out_valid, 1'b0);
        chk1("bp release in_ready",  bus.in_ready,  1'b1);
        chk32("bp second not yet accepted", 32'(bus.op), 32'h6);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk32("bp second op",  32'(bus.op), 32'h2);
        chk32("bp second op1", bus.op1,     32'h11);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk32("bp second latency", 32'(lat),    32'(ALU_LAT + 1));
        chk32("bp second result",  bus.result,  32'h33);
        chk1 ("bp second illegal", bus.illegal, 1'b0);
        @(negedge clk);

        // Reset in the middle of a MUL
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00000018;
        bus.rs_val   = 32'd3;
        bus.rt_val   = 32'd5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk32("mr exec op", 32'(bus.op), 32'h7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1 ("mr out_valid", bus.out_valid, 1'b0);
        chk1 ("mr in_ready",  bus.in_ready,  1'b1);
        chk32("mr op",        32'(bus.op),   32'h6);
        chk32("mr op1",       bus.op1,       32'h0);
        chk32("mr result",    bus.result,    32'h0);
        chk1 ("mr zero",      bus.zero,      1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        stable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stable = 1'b0;
        end
        chk1("mr no stale result", stable, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issue-side controller for the 32-bit datapath ALU. Accepts R-type instruction words with two register operands over a valid/ready handshake, decodes the funct field into the ALU's 3-bit operation code, and drives OP1/OP2/OP. It holds those signals stable for a fixed, operation-dependent number of cycles, then samples OPS/ZF and returns the result over a second valid/ready handshake. It sits between the register-file read stage and write-back and owns the multicycle timing of MUL/DIV.

Parameters:
ALU_LAT, 1, cycles OP1/OP2/OP are held before sampling for AND/OR/ADD/SUB/SLT/NOP (>=1)
MULDIV_LAT, 4, cycles held before sampling for MUL/DIV (>=1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  instruction and operands valid
IN_READY  out  1  block can accept an instruction
INSTR  in  32  instruction word; funct = INSTR[5:0]
RS_VAL  in  32  first operand
RT_VAL  in  32  second operand
OP1  out  32  to ALU OP1
OP2  out  32  to ALU OP2
OP  out  3  to ALU OP
OPS  in  32  ALU result
ZF  in  1  ALU flag; 1 when OPS is nonzero
OUT_VALID  out  1  result valid
OUT_READY  in  1  consumer accepts result
RESULT  out  32  captured ALU result
ZERO  out  1  1 when RESULT == 0 (inverse of captured ZF)
ILLEGAL  out  1  unsupported funct, qualified by OUT_VALID
DIVZ  out  1  DIV with RT_VAL == 0, qualified by OUT_VALID

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; IN_READY=1; OUT_VALID=0; OP1=OP2=0; OP=3'b110; RESULT=0; ZERO=1; ILLEGAL=0; DIVZ=0; counter=0.
- Funct decode: 100100 AND->000; 100101 OR->001; 100000 ADD->010; 100010 SUB->011; 101010 SLT->100; 011010 DIV->101; 000000 NOP->110; 011000 MUL->111. Any other funct is illegal.
- IDLE: IN_READY=1. On IN_VALID&IN_READY, register OP1<=RS_VAL, OP2<=RT_VAL, OP<=decoded code.
  - Illegal funct: OP<=110; go to DONE with RESULT=0, ZERO=1, ILLEGAL=1.
  - DIV with RT_VAL==0: OP<=110 so the ALU never divides by zero; go to DONE with RESULT=0, ZERO=1, DIVZ=1.
  - Otherwise: load counter with ALU_LAT-1, or MULDIV_LAT-1 for MUL/DIV, and go to EXEC.
- EXEC: IN_READY=0. OP1/OP2/OP are held constant. The counter decrements each cycle. In the cycle the counter reads 0: RESULT<=OPS, ZERO<=~ZF, ILLEGAL<=0, DIVZ<=0, and go to DONE. Latency from the accept edge to OUT_VALID high is ALU_LAT (or MULDIV_LAT) + 1 cycles.
- DONE: OUT_VALID=1; RESULT and flags are stable until the handshake completes. On OUT_READY, OUT_VALID drops at the next edge and the state returns to IDLE. OP1/OP2/OP keep their last values.
- IN_READY is high only in IDLE. There is no result/accept overlap: back-to-back throughput is one instruction per (latency + 2) cycles minimum.
- IN_VALID in EXEC/DONE is ignored; the input is not consumed.
- OUT_READY held high in advance: DONE lasts exactly 1 cycle.
- Reset mid-EXEC or mid-DONE: the operation is aborted and no result is produced; all outputs take reset values immediately.
- Arithmetic is performed entirely by the ALU; this block does no width conversion. RESULT is the 32-bit OPS verbatim (MUL is the low 32 bits, SLT is 0/1).

Test Plan:
- ADD: INSTR funct=100000, RS=5, RT=7, OUT_READY=1 -> OP=010 held ALU_LAT cycles; OUT_VALID at accept+2; RESULT=12, ZERO=0.
- SUB to zero: funct=100010, RS=RT=0x1234 -> RESULT=0, ZERO=1, ILLEGAL=0, DIVZ=0.
- MUL latency: funct=011000, RS=3, RT=0x10 -> OP=111 stable 4 cycles; OUT_VALID at accept+5; RESULT=0x30.
- DIV by zero: funct=011010, RT=0 -> OP stays 110; OUT_VALID next cycle; DIVZ=1, RESULT=0. Repeat with RS=100, RT=7 -> RESULT=14, DIVZ=0.
- Backpressure/illegal: funct=111111 with OUT_READY=0 for 5 cycles -> ILLEGAL=1 and OUT_VALID held; IN_READY=0 throughout; a second IN_VALID is not accepted until one cycle after OUT_READY.
- Reset mid-op: assert RST_N low during MUL EXEC -> OUT_VALID=0, IN_READY=1, OP=110 without waiting for a clock edge; no stale result after release.
